open_riscv_soc: RTL and testbench

//  Minimal single-cycle RV32I SoC: instruction ROM, PC, decoder/ALU and a 32x32 register file.
//  Top level of the phase-1 core. No external bus; only architectural state is observable.

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/open_riscv_soc_core.sv | 147 ++++++++++++++
 rtl/open_riscv_soc_regfile.sv | 29 ++
 rtl/open_riscv_soc_rom.sv | 25 ++
 rtl/open_riscv_soc.sv | 42 ++++
 tb/tb_open_riscv_soc.sv | 334 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the open_riscv_soc core: opcodes, funct fields, word type.
package riscv_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/open_riscv_soc_core.sv
// Single-cycle RV32I core: PC, decode, immediates, ALU, branch compare, register file.
// Shift instructions are built only when RV32I_SHIFT_EN is defined; otherwise they act as NOPs.
module open_risc_v
  import riscv_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t inst,
  output word_t pc
);

  word_t pc_q, pc_d, pc_plus4;
  word_t rs1_val, rs2_val, wb_data;
  word_t imm_i, imm_b, imm_j, imm_u;
  logic  wb_en, br_legal, br_taken;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};

  open_riscv_soc_regfile regs_inst (
    .clk   (clk),
    .rst   (rst),
    .raddr1(rs1),
    .raddr2(rs2),
    .rdata1(rs1_val),
    .rdata2(rs2_val),
    .we    (wb_en),
    .waddr (rd),
    .wdata (wb_data)
  );

`ifdef RV32I_SHIFT_EN
  logic [4:0] shamt;
  assign shamt = (opcode == OP) ? rs2_val[4:0] : inst[24:20];
`endif

  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d     = pc_plus4;
    wb_en    = 1'b0;
    wb_data  = '0;
    case (opcode)
      LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc_q + imm_u;
      end
      JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_d    = pc_q + imm_j;
      end
      JALR: begin
        if (funct3 == F3_JALR) begin
          wb_en   = 1'b1;
          wb_data = pc_plus4;
          pc_d    = (rs1_val + imm_i) & ~32'd1;
        end
      end
      BRANCH: begin
        if (br_legal && br_taken) pc_d = pc_q + imm_b;
      end
      OP_IMM: begin
        wb_en = 1'b1;
        case (funct3)
          F3_ADD_SUB: wb_data = rs1_val + imm_i;
          F3_SLT:     wb_data = {31'd0, $signed(rs1_val) < $signed(imm_i)};
          F3_SLTU:    wb_data = {31'd0, rs1_val < imm_i};
          F3_XOR:     wb_data = rs1_val ^ imm_i;
          F3_OR:      wb_data = rs1_val | imm_i;
          F3_AND:     wb_data = rs1_val & imm_i;
`ifdef RV32I_SHIFT_EN
          F3_SLL: begin
            wb_en   = (funct7 == F7_BASE);
            wb_data = rs1_val << shamt;
          end
          F3_SR: begin
            wb_en   = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            wb_data = (funct7 == F7_ALT) ? word_t'($signed(rs1_val) >>> shamt)
                                         : rs1_val >> shamt;
          end
`endif
          default: wb_en = 1'b0;
        endcase
      end
      OP: begin
        wb_en = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD_SUB}: wb_data = rs1_val + rs2_val;
          {F7_ALT,  F3_ADD_SUB}: wb_data = rs1_val - rs2_val;
          {F7_BASE, F3_SLT}:     wb_data = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
          {F7_BASE, F3_SLTU}:    wb_data = {31'd0, rs1_val < rs2_val};
          {F7_BASE, F3_XOR}:     wb_data = rs1_val ^ rs2_val;
          {F7_BASE, F3_OR}:      wb_data = rs1_val | rs2_val;
          {F7_BASE, F3_AND}:     wb_data = rs1_val & rs2_val;
`ifdef RV32I_SHIFT_EN
          {F7_BASE, F3_SLL}:     wb_data = rs1_val << shamt;
          {F7_BASE, F3_SR}:      wb_data = rs1_val >> shamt;
          {F7_ALT,  F3_SR}:      wb_data = word_t'($signed(rs1_val) >>> shamt);
`endif
          default:               wb_en = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/open_riscv_soc_regfile.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero.
module open_riscv_soc_regfile
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  output word_t      rdata1,
  output word_t      rdata2,
  input  logic       we,
  input  logic [4:0] waddr,
  input  word_t      wdata
);

  word_t regs [0:31];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/open_riscv_soc_rom.sv
// Instruction ROM with combinational read; contents are preloaded from outside.
// The load port is tied off at the top so the array has a formal writer.
module open_riscv_soc_rom
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output word_t         data,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  word_t         load_data
);

  word_t rom_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (load_en) rom_mem[load_addr] <= load_data;
  end

  assign data = rom_mem[addr];

endmodule

// File: rtl/open_riscv_soc.sv
// Phase-1 RV32I SoC top: instruction ROM plus single-cycle core, no external bus.
// Optional shifts are enabled with RV32I_SHIFT_EN.
module open_riscv_soc
  import riscv_pkg::*;
#(
  parameter int unsigned ROM_DEPTH = 4096,
  parameter word_t       RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned ROM_AW = $clog2(ROM_DEPTH);

  word_t pc, inst;
  logic  unused_pc_bits;

  // Fetch ignores the byte offset and wraps on the ROM size.
  assign unused_pc_bits = ^{pc[31:ROM_AW+2], pc[1:0]};

  open_riscv_soc_rom #(
    .DEPTH(ROM_DEPTH),
    .AW   (ROM_AW)
  ) rom_inst (
    .clk      (clk),
    .addr     (pc[ROM_AW+1:2]),
    .data     (inst),
    .load_en  (1'b0),
    .load_addr('0),
    .load_data('0)
  );

  open_risc_v #(
    .RESET_PC(RESET_PC)
  ) open_risc_v_inst (
    .clk (clk),
    .rst (rst),
    .inst(inst),
    .pc  (pc)
  );

endmodule

// File: tb/tb_open_riscv_soc.sv
// Scoreboard bench for open_riscv_soc: an instruction-level model predicts pc and registers per cycle.
module tb_open_riscv_soc;

`ifdef RV32I_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  open_riscv_soc #(.ROM_DEPTH(4096), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst));

  typedef struct {
    logic [31:0] pc;
    int unsigned idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] rom_model [0:4095];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] dut_reg(input int unsigned i);
    return dut.open_risc_v_inst.regs_inst.regs[i];
  endfunction

  function automatic logic [31:0] dut_pc();
    return dut.open_risc_v_inst.pc_q;
  endfunction

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  task automatic model_step(output int unsigned wr_idx);
    logic [31:0] w, a, b, ii, ib, ij, iu, nxt, val;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    bit          wr, t, ok;
    w   = rom_model[m_pc[13:2]];
    f3  = w[14:12];
    f7  = w[31:25];
    rd  = w[11:7];
    a   = m_regs[w[19:15]];
    b   = m_regs[w[24:20]];
    ii  = 32'($signed(w[31:20]));
    ib  = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    ij  = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    iu  = {w[31:12], 12'h000};
    nxt = m_pc + 32'd4;
    wr  = 1'b0;
    val = '0;
    t   = 1'b0;
    ok  = 1'b1;
    case (w[6:0])
      7'h37: begin wr = 1; val = iu; end
      7'h17: begin wr = 1; val = m_pc + iu; end
      7'h6f: begin wr = 1; val = m_pc + 32'd4; nxt = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1; val = m_pc + 32'd4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) <  $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = (a <  b);
          3'd7: t = (a >= b);
          default: t = 1'b0;
        endcase
        if (t) nxt = m_pc + ib;
      end
      7'h13: begin
        case (f3)
          3'd0: val = a + ii;
          3'd2: val = 32'($signed(a) < $signed(ii));
          3'd3: val = 32'(a < ii);
          3'd4: val = a ^ ii;
          3'd6: val = a | ii;
          3'd7: val = a & ii;
          3'd1: begin ok = SHIFT_EN && (f7 == 7'h00); val = a << w[24:20]; end
          3'd5: begin
            ok  = SHIFT_EN && ((f7 == 7'h00) || (f7 == 7'h20));
            val = (f7 == 7'h20) ? $unsigned($signed(a) >>> w[24:20]) : a >> w[24:20];
          end
          default: ok = 1'b0;
        endcase
        wr = ok;
      end
      7'h33: begin
        case ({f7, f3})
          {7'h00, 3'd0}: val = a + b;
          {7'h20, 3'd0}: val = a - b;
          {7'h00, 3'd2}: val = 32'($signed(a) < $signed(b));
          {7'h00, 3'd3}: val = 32'(a < b);
          {7'h00, 3'd4}: val = a ^ b;
          {7'h00, 3'd6}: val = a | b;
          {7'h00, 3'd7}: val = a & b;
          {7'h00, 3'd1}: begin ok = SHIFT_EN; val = a << b[4:0]; end
          {7'h00, 3'd5}: begin ok = SHIFT_EN; val = a >> b[4:0]; end
          {7'h20, 3'd5}: begin ok = SHIFT_EN; val = $unsigned($signed(a) >>> b[4:0]); end
          default:       ok = 1'b0;
        endcase
        wr = ok;
      end
      default: ;
    endcase
    wr_idx = 0;
    if (wr && rd != 5'd0) begin
      m_regs[rd] = val;
      wr_idx = rd;
    end
    m_pc = nxt;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit r);
    exp_t e;
    int unsigned idx;
    @(negedge clk);
    rst = r;
    if (r) begin
      model_reset();
      idx = 27 + $urandom_range(0, 2);
    end else begin
      model_step(idx);
      if (idx == 0) idx = $urandom_range(0, 31);
    end
    e.pc  = m_pc;
    e.idx = idx;
    e.val = m_regs[idx];
    sb_q.push_back(e);
  endtask

  task automatic load_prog(input logic [31:0] prog[$]);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rom_model[i] = '0;
      dut.rom_inst.rom_mem[i] = '0;
    end
    foreach (prog[i]) begin
      rom_model[i] = prog[i];
      dut.rom_inst.rom_mem[i] = prog[i];
    end
  endtask

  task automatic sweep();
    check("pc_final", dut_pc(), m_pc);
    for (int i = 0; i < 32; i++) check($sformatf("x%0d_final", i), dut_reg(i), m_regs[i]);
  endtask

  task automatic run_prog(input logic [31:0] prog[$], input int unsigned cycles);
    load_prog(prog);
    tick(1);
    tick(1);
    repeat (cycles) tick(0);
    @(negedge clk);
    sweep();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] off, imm;
    int unsigned kind;
    rd   = 5'($urandom_range(0, 31));
    rs1  = 5'($urandom_range(0, 31));
    rs2  = 5'($urandom_range(0, 31));
    f3   = 3'($urandom_range(0, 7));
    imm  = $urandom();
    off  = 32'($urandom_range(1, 8)) * 32'd4;
    if ($urandom_range(0, 1) == 1) off = -off;
    f7   = ($urandom_range(0, 3) == 0) ? 7'($urandom()) :
           ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    kind = $urandom_range(0, 9);
    case (kind)
      0: return $urandom();
      1: return {imm[31:12], rd, ($urandom_range(0, 1) == 1) ? 7'b0110111 : 7'b0010111};
      2, 3, 4: begin
        if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
        return enc_i(7'b0010011, f3, rd, rs1, imm);
      end
      5, 6: return enc_r(f7, f3, rd, rs1, rs2);
      7: return enc_b(f3, rs1, rs2, off);
      8: return enc_j(rd, off);
      default: return enc_i(7'b1100111, 3'd0, rd, 5'd0, 32'($urandom_range(0, 1023)));
    endcase
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("pc", dut_pc(), e.pc);
        check($sformatf("x%0d", e.idx), dut_reg(e.idx), e.val);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] prog[$];
    for (int i = 0; i < 4096; i++) begin
      rom_model[i] = '0;
      dut.rom_inst.rom_mem[i] = '0;
    end

    // ADD
    prog = '{enc_i(7'b0010011, 3'd0, 5'd27, 5'd0, 32'd5),
             enc_i(7'b0010011, 3'd0, 5'd28, 5'd0, 32'd7),
             enc_r(7'h00, 3'd0, 5'd29, 5'd27, 5'd28)};
    run_prog(prog, 3);
    check("add_x27", dut_reg(27), 32'd5);
    check("add_x28", dut_reg(28), 32'd7);
    check("add_x29", dut_reg(29), 32'd12);

    // SUB / wrap-around
    prog = '{enc_i(7'b0010011, 3'd0, 5'd27, 5'd0, -32'sd1),
             enc_r(7'h00, 3'd0, 5'd28, 5'd27, 5'd27),
             enc_r(7'h20, 3'd0, 5'd29, 5'd0, 5'd27)};
    run_prog(prog, 3);
    check("sub_x28", dut_reg(28), 32'hFFFF_FFFE);
    check("sub_x29", dut_reg(29), 32'd1);

    // Branch loop / JAL, with a mid-program reset
    prog = '{enc_i(7'b0010011, 3'd0, 5'd27, 5'd0, 32'd3),
             enc_i(7'b0010011, 3'd0, 5'd27, 5'd27, -32'sd1),
             enc_b(3'd1, 5'd27, 5'd0, -32'sd4),
             enc_j(5'd28, 32'd8),
             enc_i(7'b0010011, 3'd0, 5'd29, 5'd0, 32'd9)};
    load_prog(prog);
    tick(1); tick(1);
    repeat (4) tick(0);
    tick(1); tick(1);
    @(negedge clk);
    check("rst_pc", dut_pc(), 32'h0);
    check("rst_x27", dut_reg(27), 32'h0);
    check("rst_x28", dut_reg(28), 32'h0);
    check("rst_x29", dut_reg(29), 32'h0);
    repeat (10) tick(0);
    @(negedge clk);
    sweep();
    check("br_x27", dut_reg(27), 32'd0);
    check("br_x28", dut_reg(28), 32'd16);
    check("br_x29", dut_reg(29), 32'd0);

    // x0 write and all-zero word
    prog = '{enc_i(7'b0010011, 3'd0, 5'd0, 5'd0, 32'd7),
             32'h0,
             enc_i(7'b0010011, 3'd0, 5'd29, 5'd0, 32'd1)};
    run_prog(prog, 3);
    check("x0_zero", dut_reg(0), 32'd0);
    check("ill_x29", dut_reg(29), 32'd1);
    check("ill_pc", dut_pc(), 32'd12);

    // JALR with rd==rs1 and odd target
    prog = '{enc_i(7'b0010011, 3'd0, 5'd5, 5'd0, 32'd16),
             enc_i(7'b1100111, 3'd0, 5'd5, 5'd5, 32'd1),
             enc_i(7'b0010011, 3'd0, 5'd6, 5'd0, 32'd1),
             enc_i(7'b0010011, 3'd0, 5'd7, 5'd0, 32'd2),
             enc_i(7'b0010011, 3'd0, 5'd8, 5'd0, 32'd3)};
    run_prog(prog, 3);
    check("jalr_x5", dut_reg(5), 32'd8);
    check("jalr_x6", dut_reg(6), 32'd0);
    check("jalr_x8", dut_reg(8), 32'd3);

    // Shifts
    prog = '{enc_i(7'b0010011, 3'd0, 5'd27, 5'd0, -32'sd16),
             enc_i(7'b0010011, 3'd5, 5'd28, 5'd27, {20'd0, 7'h20, 5'd2}),
             enc_i(7'b0010011, 3'd5, 5'd29, 5'd27, {20'd0, 7'h00, 5'd28})};
    run_prog(prog, 3);
    check("sh_x27", dut_reg(27), 32'hFFFF_FFF0);
    check("sh_x28", dut_reg(28), SHIFT_EN ? 32'hFFFF_FFFC : 32'h0);
    check("sh_x29", dut_reg(29), SHIFT_EN ? 32'd15 : 32'h0);

    // Randomized programs
    for (int p = 0; p < 4; p++) begin
      prog.delete();
      for (int i = 0; i < 256; i++) prog.push_back(rand_inst());
      run_prog(prog, 300);
    end

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
